fifo_oehb_dataless: RTL and testbench

//  Dataless elastic FIFO whose consumer-facing side is registered (opaque elastic buffer at the output).
//  It is the counterpart of the input-registered dataless FIFO.

---
 rtl/fifo_oehb_dataless.sv | 64 ++++++
 tb/tb_fifo_oehb_dataless.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_oehb_dataless.sv
// Dataless elastic FIFO with a registered consumer side.
// A token counter stage feeds a one-deep output register. Total capacity is
// NUM_SLOTS+1 tokens. outs_valid comes straight from a flop. ins_ready depends
// only on the counter, never on outs_ready or ins_valid.
module fifo_oehb_dataless #(
    parameter int unsigned NUM_SLOTS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ins_valid,
    output logic ins_ready,
    output logic outs_valid,
    input  logic outs_ready
);

    localparam int unsigned CW = (NUM_SLOTS < 1) ? 1 : $clog2(NUM_SLOTS + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(NUM_SLOTS);

    // Reject a counter stage with no slots at elaboration time
    generate
        if (NUM_SLOTS < 1) begin : g_bad_num_slots
            $error("fifo_oehb_dataless: NUM_SLOTS must be >= 1");
        end
    endgenerate

    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          oreg_valid;
    logic          oreg_valid_next;
    logic          accept;
    logic          oreg_free;
    logic          stage_valid;
    logic          load;

    // Handshake terms; an empty counter lets an arriving token bypass into the register
    always_comb begin
        ins_ready       = (count != COUNT_FULL);
        accept          = ins_valid & ins_ready;
        oreg_free       = ~oreg_valid | outs_ready;
        stage_valid     = (count != '0) | ins_valid;
        load            = stage_valid & oreg_free;
        count_next      = count + CW'(accept) - CW'(load);
        oreg_valid_next = oreg_valid;
        if (load) begin
            oreg_valid_next = 1'b1;
        end else if (outs_ready) begin
            oreg_valid_next = 1'b0;
        end
    end

    // State update; reset discards every held token
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            oreg_valid <= 1'b0;
        end else begin
            count      <= count_next;
            oreg_valid <= oreg_valid_next;
        end
    end

    assign outs_valid = oreg_valid;

endmodule

// File: tb/tb_fifo_oehb_dataless.sv
// Bench for fifo_oehb_dataless (NUM_SLOTS=2). Directed steps push hand-computed
// expected outputs into a queue that a negedge monitor pops and compares; a
// token scoreboard tracks every accepted token until it leaves the block.
module tb_fifo_oehb_dataless;

    logic clk;
    logic rst;
    logic ins_valid;
    logic ins_ready;
    logic outs_valid;
    logic outs_ready;

    int tests;
    int fails;

    typedef struct {
        int   tid;
        int   cyc;
        logic ir;
        logic ov;
    } exp_t;

    exp_t exp_q[$];
    int   tok_q[$];
    int   tok_in;
    logic prev_ov;
    logic prev_or;
    logic chk_loss;

    fifo_oehb_dataless #(.NUM_SLOTS(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ins_valid  (ins_valid),
        .ins_ready  (ins_ready),
        .outs_valid (outs_valid),
        .outs_ready (outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops expected outputs and tracks tokens away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            tests++;
            if (ins_ready !== e.ir || outs_valid !== e.ov) begin
                fails++;
                $display("FAIL step t%0d c%0d: ins_ready=%b outs_valid=%b, expected ins_ready=%b outs_valid=%b",
                         e.tid, e.cyc, ins_ready, outs_valid, e.ir, e.ov);
            end
        end
        if (rst) begin
            tok_q.delete();
            prev_ov = 1'b0;
            prev_or = 1'b0;
        end else begin
            if (prev_ov && !prev_or) begin
                tests++;
                if (outs_valid !== 1'b1) begin
                    fails++;
                    $display("FAIL hold: outs_valid=%b dropped without outs_ready, expected 1", outs_valid);
                end
            end
            if (ins_valid && ins_ready) begin
                tok_q.push_back(tok_in);
                tok_in++;
            end
            if (outs_valid && outs_ready) begin
                tests++;
                if (tok_q.size() == 0) begin
                    fails++;
                    $display("FAIL dup: token emitted with 0 held, expected >= 1 held");
                end else begin
                    void'(tok_q.pop_front());
                end
            end
            tests++;
            if (tok_q.size() > 3) begin
                fails++;
                $display("FAIL occ: %0d tokens held, expected <= 3", tok_q.size());
            end
            prev_ov = outs_valid;
            prev_or = outs_ready;
        end
    end

    // One clock of stimulus with its hand-computed expected outputs
    task automatic step(input int tid, input int cyc, input logic iv, input logic ordy,
                        input logic eir, input logic eov);
        exp_t e;
        ins_valid  = iv;
        outs_ready = ordy;
        e.tid = tid; e.cyc = cyc; e.ir = eir; e.ov = eov;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_now(input string name, input logic eir, input logic eov);
        tests++;
        if (ins_ready !== eir || outs_valid !== eov) begin
            fails++;
            $display("FAIL %s: ins_ready=%b outs_valid=%b, expected ins_ready=%b outs_valid=%b",
                     name, ins_ready, outs_valid, eir, eov);
        end
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (tok_q.size() != 0) begin
            fails++;
            $display("FAIL %s: %0d tokens still held, expected 0", name, tok_q.size());
        end
    endtask

    // Fill an empty FIFO to full with outs_ready low
    task automatic fill(input int tid);
        step(tid, 0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(tid, 1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(tid, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        tok_in     = 0;
        prev_ov    = 1'b0;
        prev_or    = 1'b0;
        chk_loss   = 1'b0;
        ins_valid  = 1'b0;
        outs_ready = 1'b0;
        rst        = 1'b1;
        #1;
        check_now("reset_state", 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_now("after_release", 1'b1, 1'b0);

        // Single token, consumer ready: one cycle of outs_valid
        step(2, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        step(2, 1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(2, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        step(2, 3, 1'b0, 1'b1, 1'b1, 1'b0);

        // Fill with consumer stalled; 4th offer refused
        fill(3);
        step(3, 3, 1'b1, 1'b0, 1'b0, 1'b1);
        step(3, 4, 1'b1, 1'b0, 1'b0, 1'b1);

        // Drain: exactly three cycles of outs_valid
        step(4, 0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(4, 1, 1'b0, 1'b1, 1'b1, 1'b1);
        step(4, 2, 1'b0, 1'b1, 1'b1, 1'b1);
        step(4, 3, 1'b0, 1'b1, 1'b1, 1'b0);
        step(4, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("drain4");

        // Streaming 10 tokens at full throughput
        step(5, 0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int c = 1; c < 10; c++) step(5, c, 1'b1, 1'b1, 1'b1, 1'b1);
        step(5, 10, 1'b0, 1'b1, 1'b1, 1'b1);
        step(5, 11, 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("stream5");

        // Full with both sides active: no accept, count drops by one
        fill(6);
        step(6, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        step(6, 4, 1'b0, 1'b0, 1'b1, 1'b1);
        step(6, 5, 1'b0, 1'b1, 1'b1, 1'b1);
        step(6, 6, 1'b0, 1'b1, 1'b1, 1'b1);
        step(6, 7, 1'b0, 1'b1, 1'b1, 1'b0);
        check_drained("full6");

        // Async reset while holding tokens discards them
        fill(1);
        ins_valid  = 1'b0;
        outs_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_now("async_reset", 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_now("reset_hold", 1'b1, 1'b0);
        rst = 1'b0;
        step(1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1, 1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1, 2, 1'b0, 1'b1, 1'b1, 1'b0);

        // Random traffic checked by the token scoreboard only
        for (int c = 0; c < 400; c++) begin
            ins_valid  = 1'($urandom_range(0, 1));
            outs_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        ins_valid  = 1'b0;
        outs_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check_drained("random_loss");
        check_now("random_idle", 1'b1, 1'b0);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
